fetch_aligner: RTL and testbench

FETCH_ALIGNER -- requirements
Module: fetch_aligner

---
 rtl/fetch_aligner.sv | 113 +++++++++++
 tb/tb_fetch_aligner.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_aligner.sv
// Fetch aligner: buffers halfwords from word-aligned fetches and presents
// complete 16-bit (RVC) or 32-bit instructions with their PC.
module fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic [31:0] fetch_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_rvc,
    output logic [31:0] out_pc
);

    localparam int unsigned HW_W  = 16;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned CNT_W = 2;

    logic [HW_W-1:0]  hb_q [DEPTH];
    logic [HW_W-1:0]  hb_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      pc_q, pc_d;
    logic             skip_lo_q, skip_lo_d;

    logic             out_fire;
    logic             fetch_fire;
    logic [CNT_W-1:0] consumed;
    logic [CNT_W-1:0] remain;

    // Handshake and presentation; reset and flush mask both handshakes.
    always_comb begin
        out_rvc     = (hb_q[0][1:0] != 2'b11);
        fetch_ready = !rst && !flush && (count_q <= 2'd1);
        out_valid   = !rst && !flush &&
                      (out_rvc ? (count_q >= 2'd1) : (count_q >= 2'd2));
        out_instr   = out_rvc ? {16'h0000, hb_q[0]} : {hb_q[1], hb_q[0]};
        out_pc      = pc_q;
    end

    // Next state: shift out consumed halfwords, then append behind the rest.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            hb_d[i] = hb_q[i];
        end
        count_d    = count_q;
        pc_d       = pc_q;
        skip_lo_d  = skip_lo_q;

        fetch_fire = fetch_valid && fetch_ready;
        out_fire   = out_valid && out_ready;
        consumed   = out_fire ? (out_rvc ? 2'd1 : 2'd2) : 2'd0;
        remain     = count_q - consumed;

        unique case (consumed)
            2'd1: begin
                hb_d[0] = hb_q[1];
                hb_d[1] = hb_q[2];
            end
            2'd2: begin
                hb_d[0] = hb_q[2];
            end
            default: begin
            end
        endcase

        pc_d    = pc_q + 32'({consumed, 1'b0});
        count_d = remain;

        // fetch_ready guarantees remain <= 1, so appends stay inside the buffer
        if (fetch_fire) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == remain) begin
                    hb_d[i] = skip_lo_q ? fetch_data[31:16] : fetch_data[15:0];
                end else if (!skip_lo_q && (CNT_W'(i) == remain + 2'd1)) begin
                    hb_d[i] = fetch_data[31:16];
                end
            end
            count_d   = remain + (skip_lo_q ? 2'd1 : 2'd2);
            skip_lo_d = 1'b0;
        end

        if (flush) begin
            count_d   = '0;
            pc_d      = {flush_pc[31:1], 1'b0};
            skip_lo_d = flush_pc[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            pc_q      <= {RESET_PC[31:1], 1'b0};
            skip_lo_q <= RESET_PC[1];
        end else begin
            count_q   <= count_d;
            pc_q      <= pc_d;
            skip_lo_q <= skip_lo_d;
        end
    end

    // Buffer data needs no reset; count qualifies every entry.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            hb_q[i] <= hb_d[i];
        end
    end

endmodule

// File: tb/tb_fetch_aligner.sv
// Randomized bench for fetch_aligner: a halfword-queue reference model
// predicts handshakes and the instruction stream, checked every cycle.
module tb_fetch_aligner;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] flush_pc;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_rvc;
    logic [31:0] out_pc;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    fetch_aligner #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_data  (fetch_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_rvc     (out_rvc),
        .out_pc      (out_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;

    // Reference model: the pending halfword stream and the PC of its head.
    logic [15:0] hq [$];
    logic [31:0] mpc;
    logic        mskip;
    bit          live = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare at the falling edge, then advance the model to the next rising edge.
    always @(negedge clk) begin
        bit          ev;
        bit          efr;
        bit          er;
        logic [31:0] ei;
        ev = 0; er = 0; ei = '0;
        if (live && hq.size() >= 1) begin
            er = (hq[0][1:0] != 2'b11);
            if (er) begin
                ev = 1; ei = {16'h0000, hq[0]};
            end else if (hq.size() >= 2) begin
                ev = 1; ei = {hq[1], hq[0]};
            end
        end
        if (rst || flush) ev = 0;
        efr = !flush && (hq.size() <= 1);

        if (rst || live) chk("out_valid", 32'(out_valid), 32'(ev));
        if (live && !rst) chk("fetch_ready", 32'(fetch_ready), 32'(efr));
        if (ev) begin
            chk("out_instr", out_instr, ei);
            chk("out_rvc", 32'(out_rvc), 32'(er));
            chk("out_pc", out_pc, mpc);
        end

        if (rst) begin
            hq.delete();
            mpc   = {RST_PC[31:1], 1'b0};
            mskip = RST_PC[1];
            live  = 1;
        end else if (live) begin
            if (flush) begin
                hq.delete();
                mpc   = {flush_pc[31:1], 1'b0};
                mskip = flush_pc[1];
            end else begin
                if (ev && out_ready) begin
                    n_out++;
                    if (er) begin
                        void'(hq.pop_front());
                        mpc = mpc + 32'd2;
                    end else begin
                        void'(hq.pop_front());
                        void'(hq.pop_front());
                        mpc = mpc + 32'd4;
                    end
                end
                if (efr && fetch_valid) begin
                    if (!mskip) hq.push_back(fetch_data[15:0]);
                    hq.push_back(fetch_data[31:16]);
                    mskip = 0;
                end
            end
        end
    end

    task automatic drive(input logic r, input logic f, input logic [31:0] fpc,
                         input logic fv, input logic [31:0] fd, input logic ordy);
        @(posedge clk);
        #1;
        rst = r; flush = f; flush_pc = fpc;
        fetch_valid = fv; fetch_data = fd; out_ready = ordy;
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) drive(0, 0, 32'h0, 0, 32'h0, ordy);
    endtask

    function automatic logic [15:0] rhw();
        logic [15:0] h;
        h = 16'($urandom);
        if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
        return h;
    endfunction

    initial begin
        rst = 1; flush = 0; flush_pc = '0;
        fetch_valid = 0; fetch_data = '0; out_ready = 0;
        drive(1, 0, 32'h0, 0, 32'h0, 1);
        drive(1, 1, 32'h0, 1, 32'h0000_0013, 1);
        idle(2, 1);

        // single 32-bit instruction
        drive(0, 0, 32'h0, 1, 32'h0000_0013, 1);
        idle(3, 1);
        // two RVC from one word
        drive(0, 0, 32'h0, 1, 32'h0001_4505, 1);
        idle(3, 1);
        // straddling 32-bit instruction
        drive(0, 0, 32'h0, 1, 32'h0013_4505, 1);
        idle(3, 1);
        drive(0, 0, 32'h0, 1, 32'h0000_0000, 1);
        idle(4, 1);
        // flush to halfword-offset target
        drive(0, 1, 32'h0000_0102, 0, 32'h0, 1);
        drive(0, 0, 32'h0, 1, 32'h4505_ABCD, 1);
        idle(3, 1);
        // stall with a full buffer, then drain
        drive(0, 1, 32'h0000_0202, 0, 32'h0, 0);
        drive(0, 0, 32'h0, 1, 32'h0001_0001, 0);
        drive(0, 0, 32'h0, 1, 32'h0005_0009, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 32'h0, 1, 32'hFFFF_FFFF, 0);
        idle(5, 1);
        // flush colliding with both handshakes
        drive(0, 0, 32'h0, 1, 32'h0001_0001, 0);
        drive(0, 1, 32'h0000_0400, 1, 32'h0013_0013, 1);
        idle(3, 1);

        // randomized phase
        for (int c = 0; c < 3000; c++) begin
            logic r;
            logic f;
            r = ($urandom_range(0, 299) == 0);
            f = ($urandom_range(0, 39) == 0);
            drive(r, f, $urandom, ($urandom_range(0, 9) < 6), {rhw(), rhw()},
                  ($urandom_range(0, 9) < 7));
        end
        idle(6, 1);

        chk("out_count_min", 32'(n_out > 200), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
